// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for the nibble-in / word-out flushable FIFO: drains whole words,
// flushes stranded partial data on command or idle timeout, and buffers words for a valid/ready sink.
module fifo_drain_ctrl #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter int TW      = 8,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_vld_rd_data,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_rd_data,
    input  logic          fifo_flush_done,
    output logic          fifo_rd,
    output logic          fifo_flush_req,
    input  logic          flush_cmd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_flush,
    output logic          flush_done,
    output logic [CW-1:0] flush_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;
    typedef struct packed {
        logic          flush;
        logic [DW-1:0] data;
    } entry_t;

    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    entry_t        ob [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic          room, push, pop, flush_go, flush_end;

    // Room comes from the registered count only, so out_ready never reaches fifo_rd.
    // rst also gates the strobe so it drops the instant reset asserts.
    assign room      = (count < 2'd2);
    assign push      = rst && room && !fifo_empty && (fifo_vld_rd_data || state == FLUSH);
    assign pop       = out_valid && out_ready;
    assign flush_go  = flush_cmd && !fifo_empty;
    assign flush_end = (state == FLUSH) && fifo_flush_done;

    assign fifo_rd   = push;
    assign out_valid = (count != 2'd0);
    assign out_data  = ob[rd_ptr].data;
    assign out_flush = ob[rd_ptr].flush;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                if (flush_go) begin
                    state_nxt = FLUSH;
                end else if (TIMEOUT != 0 && !fifo_empty && !fifo_vld_rd_data) begin
                    state_nxt = WAIT;
                    timer_nxt = TW'(1);
                end
            end
            WAIT: begin
                if (flush_go) begin
                    state_nxt = FLUSH;
                    timer_nxt = '0;
                end else if (fifo_empty || fifo_vld_rd_data) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (timer >= T_LAST) begin
                    state_nxt = FLUSH;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            FLUSH: begin
                if (fifo_flush_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            timer          <= '0;
            fifo_flush_req <= 1'b0;
            flush_done     <= 1'b0;
            flush_cnt      <= '0;
        end else begin
            state          <= state_nxt;
            timer          <= timer_nxt;
            fifo_flush_req <= (state_nxt == FLUSH);
            flush_done     <= flush_end;
            if (flush_end && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Two-entry skid buffer; a word is tagged with the state it was read in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) ob[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                ob[wr_ptr] <= '{flush: (state == FLUSH), data: fifo_rd_data};
                wr_ptr     <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a cycle table for the basic read/flush handshake, then a small
// FIFO model with a word scoreboard for throughput, backpressure, timeout and reset sequences.
module tb_fifo_drain_ctrl;
    localparam int DW = 32, TIMEOUT = 64, TW = 8, CW = 8;

    logic          clk = 1'b0, rst = 1'b0;
    logic          fifo_vld_rd_data = 1'b0, fifo_empty = 1'b1, fifo_flush_done = 1'b0;
    logic          flush_cmd = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd, fifo_flush_req, out_valid, out_flush, flush_done;
    logic [DW-1:0] out_data;
    logic [CW-1:0] flush_cnt;

    fifo_drain_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT), .TW(TW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .fifo_vld_rd_data(fifo_vld_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_flush_done(fifo_flush_done),
        .fifo_rd(fifo_rd), .fifo_flush_req(fifo_flush_req), .flush_cmd(flush_cmd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flush(out_flush), .flush_done(flush_done), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // in = {empty, vld, flush_cmd, fifo_flush_done, out_ready}
    // ex = {fifo_rd, out_valid, out_flush, fifo_flush_req, flush_done}
    typedef struct {
        logic [4:0]    in;
        logic [DW-1:0] data;
        logic [4:0]    ex;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_cnt;
    } vec_t;
    vec_t vt [13];

    // FIFO model and scoreboard
    logic [DW-1:0] words [$];
    logic [DW:0]   exp_q [$];
    int            part_n = 0;
    logic [DW-1:0] part_val = '0;
    int            mcount = 0, rd_total = 0, rd_run = 0, rd_run_max = 0, fd_pulses = 0;
    logic          freq_s = 1'b0;

    task automatic drive();
        fifo_vld_rd_data = (words.size() > 0);
        fifo_empty       = (words.size() == 0) && (part_n == 0);
        fifo_rd_data     = (words.size() > 0) ? words[0] : '0;
        fifo_flush_done  = fifo_flush_req && fifo_empty;
    endtask

    task automatic add_nib(input int n, input logic [3:0] first);
        logic [3:0] nib;
        nib = first;
        for (int i = 0; i < n; i++) begin
            part_val = part_val | (DW'(nib) << (4 * part_n));
            part_n++;
            nib = nib + 4'd1;
            if (part_n == 8) begin
                words.push_back(part_val);
                part_n   = 0;
                part_val = '0;
            end
        end
    endtask

    task automatic clr_stats();
        rd_total = 0; rd_run = 0; rd_run_max = 0; fd_pulses = 0;
    endtask

    task automatic tick();
        logic       rd, pop;
        logic [DW:0] e;
        @(negedge clk);
        rd     = fifo_rd;
        pop    = out_valid && out_ready;
        freq_s = fifo_flush_req;
        chk("out_valid", out_valid, mcount != 0);
        chk("rd_when_full", rd && (mcount >= 2), 1'b0);
        if (pop) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL extra_word: got %0h/%0b, none expected", out_data, out_flush);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e[DW-1:0]);
                chk("out_flush", out_flush, e[DW]);
            end
        end
        if (flush_done) fd_pulses++;
        if (rd) begin rd_total++; rd_run++; end else rd_run = 0;
        if (rd_run > rd_run_max) rd_run_max = rd_run;
        mcount = mcount + int'(rd) - int'(pop);
        @(posedge clk); #1;
        if (rd) begin
            if (words.size() > 0) void'(words.pop_front());
            else begin
                n_cmp++; n_bad++;
                $display("FAIL rd_empty: got fifo_rd=1, expected no read of empty FIFO");
            end
        end
        if (fifo_flush_req && part_n > 0) begin
            words.push_back(part_val);
            part_n   = 0;
            part_val = '0;
        end
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic measure_rise(output int rise);
        rise = 0;
        for (int i = 1; i <= 200 && rise == 0; i++) begin
            tick();
            if (freq_s) rise = i;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        vt[0]  = '{5'b10000, 32'h0,        5'b00000, 32'h0,        8'd0};
        vt[1]  = '{5'b01000, 32'hA1A1_0001, 5'b10000, 32'h0,        8'd0};
        vt[2]  = '{5'b01000, 32'hA2A2_0002, 5'b11000, 32'hA1A1_0001, 8'd0};
        vt[3]  = '{5'b01000, 32'hA3A3_0003, 5'b01000, 32'hA1A1_0001, 8'd0};
        vt[4]  = '{5'b01001, 32'hA3A3_0003, 5'b01000, 32'hA1A1_0001, 8'd0};
        vt[5]  = '{5'b01001, 32'hA3A3_0003, 5'b11000, 32'hA2A2_0002, 8'd0};
        vt[6]  = '{5'b10100, 32'h0,        5'b01000, 32'hA3A3_0003, 8'd0};
        vt[7]  = '{5'b10000, 32'h0,        5'b01000, 32'hA3A3_0003, 8'd0};
        vt[8]  = '{5'b00101, 32'h0,        5'b01000, 32'hA3A3_0003, 8'd0};
        vt[9]  = '{5'b00001, 32'hB1B1_00B1, 5'b10010, 32'h0,        8'd0};
        vt[10] = '{5'b10011, 32'h0,        5'b01110, 32'hB1B1_00B1, 8'd0};
        vt[11] = '{5'b10001, 32'h0,        5'b00001, 32'h0,        8'd1};
        vt[12] = '{5'b10001, 32'h0,        5'b00000, 32'h0,        8'd1};

        // reset state
        #12;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.flush_req", fifo_flush_req, 1'b0);
        chk("rst.flush_done", flush_done, 1'b0);
        chk("rst.flush_cnt", flush_cnt, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.fifo_rd", fifo_rd, 1'b0);
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            {fifo_empty, fifo_vld_rd_data, flush_cmd, fifo_flush_done, out_ready} = vt[i].in;
            fifo_rd_data = vt[i].data;
            @(negedge clk);
            chk($sformatf("v%0d.fifo_rd", i), fifo_rd, vt[i].ex[4]);
            chk($sformatf("v%0d.out_valid", i), out_valid, vt[i].ex[3]);
            if (vt[i].ex[3]) begin
                chk($sformatf("v%0d.out_data", i), out_data, vt[i].e_data);
                chk($sformatf("v%0d.out_flush", i), out_flush, vt[i].ex[2]);
            end
            chk($sformatf("v%0d.flush_req", i), fifo_flush_req, vt[i].ex[1]);
            chk($sformatf("v%0d.flush_done", i), flush_done, vt[i].ex[0]);
            chk($sformatf("v%0d.flush_cnt", i), flush_cnt, vt[i].e_cnt);
            @(posedge clk); #1;
        end

        // fresh start for the model-driven sequences
        flush_cmd = 1'b0; out_ready = 1'b0; rst = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        drive();

        // 16 words, sink always ready
        clr_stats();
        for (int i = 0; i < 16; i++) begin
            words.push_back(32'hA000_0000 + i);
            exp_q.push_back({1'b0, 32'hA000_0000 + i});
        end
        out_ready = 1'b1;
        drive();
        run(30);
        chk("s1.rd_run", rd_run_max, 16);
        chk("s1.rd_total", rd_total, 16);
        chk("s1.left", exp_q.size(), 0);

        // 16 words, sink toggling
        clr_stats();
        for (int i = 0; i < 16; i++) begin
            words.push_back(32'hB000_0000 + i);
            exp_q.push_back({1'b0, 32'hB000_0000 + i});
        end
        drive();
        for (int i = 0; i < 80; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        chk("s2.rd_total", rd_total, 16);
        chk("s2.left", exp_q.size(), 0);

        // 3 nibbles stranded: auto flush
        clr_stats();
        out_ready = 1'b1;
        add_nib(3, 4'h1);
        exp_q.push_back({1'b1, 32'h0000_0321});
        drive();
        measure_rise(r);
        chk("s3.auto_latency", r, TIMEOUT + 1);
        run(10);
        chk("s3.left", exp_q.size(), 0);
        chk("s3.fd_pulses", fd_pulses, 1);
        chk("s3.flush_cnt", flush_cnt, 1);

        // partial completes during WAIT: no flush, then timer restarts
        clr_stats();
        add_nib(3, 4'h1);
        drive();
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("s4.no_flush", freq_s, 1'b0);
        end
        add_nib(5, 4'h4);
        exp_q.push_back({1'b0, 32'h8765_4321});
        drive();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s4.no_flush2", freq_s, 1'b0);
        end
        chk("s4.word_left", exp_q.size(), 0);
        add_nib(2, 4'h9);
        exp_q.push_back({1'b1, 32'h0000_00A9});
        drive();
        measure_rise(r);
        chk("s4.restart_latency", r, TIMEOUT + 1);
        run(10);
        chk("s4.left", exp_q.size(), 0);
        chk("s4.fd_pulses", fd_pulses, 1);
        chk("s4.flush_cnt", flush_cnt, 2);

        // flush_cmd with 2 words + 5 nibbles under backpressure
        clr_stats();
        words.push_back(32'hC0DE_0001);
        words.push_back(32'hC0DE_0002);
        add_nib(5, 4'h1);
        exp_q.push_back({1'b0, 32'hC0DE_0001});
        exp_q.push_back({1'b1, 32'hC0DE_0002});
        exp_q.push_back({1'b1, 32'h0005_4321});
        out_ready = 1'b0;
        flush_cmd = 1'b1;
        drive();
        tick();
        flush_cmd = 1'b0;
        run(9);
        chk("s5.stall_reads", rd_total, 2);
        chk("s5.flush_req", freq_s, 1'b1);
        out_ready = 1'b1;
        run(12);
        chk("s5.left", exp_q.size(), 0);
        chk("s5.fd_pulses", fd_pulses, 1);
        chk("s5.flush_cnt", flush_cnt, 3);

        // flush_cmd while empty is dropped
        flush_cmd = 1'b1;
        tick();
        flush_cmd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s5.empty_cmd", freq_s, 1'b0);
        end

        // reset mid-flush with a full buffer
        words.push_back(32'hD00D_0001);
        words.push_back(32'hD00D_0002);
        add_nib(3, 4'h1);
        exp_q.push_back({1'b0, 32'hD00D_0001});
        exp_q.push_back({1'b1, 32'hD00D_0002});
        out_ready = 1'b0;
        flush_cmd = 1'b1;
        drive();
        tick();
        flush_cmd = 1'b0;
        run(3);
        chk("s6.pre_flush_req", freq_s, 1'b1);
        chk("s6.pre_count", mcount, 2);
        rst = 1'b0;
        #1;
        chk("s6.out_valid", out_valid, 1'b0);
        chk("s6.flush_req", fifo_flush_req, 1'b0);
        chk("s6.fifo_rd", fifo_rd, 1'b0);
        chk("s6.flush_done", flush_done, 1'b0);
        chk("s6.flush_cnt", flush_cnt, 0);
        words.delete(); exp_q.delete();
        part_n = 0; part_val = '0; mcount = 0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s6.post_flush_req", freq_s, 1'b0);
        end
        chk("s6.post_cnt", flush_cnt, 0);
        words.push_back(32'h600D_0001);
        exp_q.push_back({1'b0, 32'h600D_0001});
        out_ready = 1'b1;
        drive();
        run(5);
        chk("s6.left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
